// File: rtl/prt_scaler_hups.sv
// rtl/prt_scaler_hups.sv - horizontal 2x video upscaler (bypass / nearest / bilinear)
// Each accepted word expands into two output beats; bilinear holds one word back to see its right neighbour.
module prt_scaler_hups #(
  parameter int P_PPC = 4,
  parameter int P_BPC = 8,
  parameter int P_CPP = 3
) (
  input  logic                           RST_IN,
  input  logic                           CLK_IN,
  input  logic                           CTL_RUN_IN,
  input  logic [1:0]                     CTL_MODE_IN,
  input  logic                           HS_IN,
  input  logic [P_PPC*P_CPP*P_BPC-1:0]   DAT_IN,
  input  logic                           WR_IN,
  output logic                           RDY_OUT,
  output logic                           HS_OUT,
  output logic [P_PPC*P_CPP*P_BPC-1:0]   DAT_OUT,
  output logic                           DE_OUT,
  output logic                           ERR_OUT
);
  localparam int PW = P_CPP * P_BPC;
  localparam int W  = P_PPC * PW;
  localparam logic [1:0] M_NEAREST  = 2'd1;
  localparam logic [1:0] M_BILINEAR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BEAT1} state_t;
  state_t state_r, state_nx;

  logic         run_prev_r, hs_prev_r, hs_d1_r, hs_d2_r;
  logic [1:0]   mode_r, mode_eff;
  logic [W-1:0] pend_r, beat1_r;
  logic         last_r, last_nx, flush_r, flush_nx;
  logic         run, run_rise, hs_edge, is_nn, is_bl, is_byp;
  logic         rdy, wr_ok, wr_bad;
  logic         emit0, emit1, load_pend;
  logic [W-1:0]    src;
  logic [PW-1:0]   nxt_pix;
  logic [W+PW-1:0] ext;
  logic [2*W-1:0]  exp2;

  function automatic logic [P_BPC-1:0] avg(input logic [P_BPC-1:0] a, input logic [P_BPC-1:0] b);
    logic [P_BPC:0] s;
    s = {1'b0, a} + {1'b0, b} + {{P_BPC{1'b0}}, 1'b1};
    return P_BPC'(s >> 1);
  endfunction

  // The mode is sampled on the run rising edge and usable in that same cycle.
  assign run      = CTL_RUN_IN;
  assign run_rise = run & ~run_prev_r;
  assign mode_eff = run_rise ? CTL_MODE_IN : mode_r;
  assign is_nn    = (mode_eff == M_NEAREST);
  assign is_bl    = (mode_eff == M_BILINEAR);
  assign is_byp   = ~(is_nn | is_bl);
  assign hs_edge  = HS_IN & ~hs_prev_r;
  assign rdy      = run & (state_r != S_BEAT1) & ~flush_r;
  assign wr_ok    = WR_IN & rdy & ~hs_edge;
  assign wr_bad   = run & WR_IN & ~wr_ok;
  assign RDY_OUT  = ~RST_IN & rdy;

  always_comb begin
    state_nx  = state_r;
    last_nx   = last_r;
    flush_nx  = flush_r;
    emit0     = 1'b0;
    emit1     = 1'b0;
    load_pend = 1'b0;
    if (!run || is_byp) begin
      state_nx = S_IDLE;
      last_nx  = 1'b0;
      flush_nx = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (wr_ok) begin
            if (is_nn) begin
              emit0    = 1'b1;
              state_nx = S_BEAT1;
            end else begin
              load_pend = 1'b1;
              state_nx  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (flush_r || hs_edge) begin
            emit0    = 1'b1;
            last_nx  = 1'b1;
            flush_nx = 1'b0;
            state_nx = S_BEAT1;
          end else if (wr_ok) begin
            emit0     = 1'b1;
            load_pend = 1'b1;
            last_nx   = 1'b0;
            state_nx  = S_BEAT1;
          end
        end
        default: begin
          emit1 = 1'b1;
          if (last_r || !is_bl) begin
            state_nx = S_IDLE;
            last_nx  = 1'b0;
            flush_nx = 1'b0;
          end else begin
            state_nx = S_HOLD;
            if (hs_edge) flush_nx = 1'b1;
          end
        end
      endcase
    end
  end

  // Right neighbour of the last pixel: next word's first pixel, or itself at line end.
  always_comb begin
    src     = (state_r == S_HOLD) ? pend_r : DAT_IN;
    nxt_pix = ((state_r == S_HOLD) && !(flush_r || hs_edge)) ? DAT_IN[PW-1:0] : src[W-1 -: PW];
    ext     = {nxt_pix, src};
    exp2    = '0;
    for (int i = 0; i < P_PPC; i++) begin
      for (int c = 0; c < P_CPP; c++) begin
        exp2[(2*i*P_CPP+c)*P_BPC +: P_BPC] = ext[(i*P_CPP+c)*P_BPC +: P_BPC];
        exp2[((2*i+1)*P_CPP+c)*P_BPC +: P_BPC] = is_nn ? ext[(i*P_CPP+c)*P_BPC +: P_BPC]
            : avg(ext[(i*P_CPP+c)*P_BPC +: P_BPC], ext[((i+1)*P_CPP+c)*P_BPC +: P_BPC]);
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_r    <= S_IDLE;
      run_prev_r <= 1'b0;
      hs_prev_r  <= 1'b0;
      hs_d1_r    <= 1'b0;
      hs_d2_r    <= 1'b0;
      mode_r     <= 2'd0;
      pend_r     <= '0;
      beat1_r    <= '0;
      last_r     <= 1'b0;
      flush_r    <= 1'b0;
      HS_OUT     <= 1'b0;
      DAT_OUT    <= '0;
      DE_OUT     <= 1'b0;
      ERR_OUT    <= 1'b0;
    end else begin
      run_prev_r <= run;
      hs_prev_r  <= HS_IN;
      if (run_rise) mode_r <= CTL_MODE_IN;
      hs_d1_r    <= HS_IN & run;
      hs_d2_r    <= hs_d1_r & run;
      HS_OUT     <= hs_d2_r & run;
      state_r    <= state_nx;
      last_r     <= last_nx;
      flush_r    <= flush_nx;
      ERR_OUT    <= run & (ERR_OUT | wr_bad);
      if (load_pend) pend_r <= DAT_IN;
      if (!run) begin
        DE_OUT <= 1'b0;
      end else if (is_byp) begin
        DAT_OUT <= DAT_IN;
        DE_OUT  <= wr_ok;
      end else if (emit0) begin
        DAT_OUT <= exp2[W-1:0];
        beat1_r <= exp2[2*W-1:W];
        DE_OUT  <= 1'b1;
      end else if (emit1) begin
        DAT_OUT <= beat1_r;
        DE_OUT  <= 1'b1;
      end else begin
        DE_OUT <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prt_scaler_hups.sv
// tb/tb_prt_scaler_hups.sv - directed bench for prt_scaler_hups with an output scoreboard
module tb_prt_scaler_hups;
  localparam int PPC = 4;
  localparam int BPC = 8;
  localparam int CPP = 3;
  localparam int PW  = CPP * BPC;
  localparam int W   = PPC * PW;

  logic         RST_IN, CLK_IN, CTL_RUN_IN, HS_IN, WR_IN;
  logic [1:0]   CTL_MODE_IN;
  logic [W-1:0] DAT_IN, DAT_OUT;
  logic         RDY_OUT, HS_OUT, DE_OUT, ERR_OUT;

  prt_scaler_hups #(.P_PPC(PPC), .P_BPC(BPC), .P_CPP(CPP)) dut (
    .RST_IN(RST_IN), .CLK_IN(CLK_IN), .CTL_RUN_IN(CTL_RUN_IN), .CTL_MODE_IN(CTL_MODE_IN),
    .HS_IN(HS_IN), .DAT_IN(DAT_IN), .WR_IN(WR_IN), .RDY_OUT(RDY_OUT), .HS_OUT(HS_OUT),
    .DAT_OUT(DAT_OUT), .DE_OUT(DE_OUT), .ERR_OUT(ERR_OUT)
  );

  typedef struct { int cyc; logic [W-1:0] dat; } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] got_q[$];
  int           n_chk = 0, n_err = 0, cyc = 0;
  logic         chk_en = 1'b0, exp_err = 1'b0;
  logic         hs_h[8], run_h[8], rst_h[8];

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Reference expansion: pixel i -> (p_i, p_i) for nearest, (p_i, rounded mean with right neighbour) for bilinear.
  function automatic logic [2*W-1:0] expand(input logic [W-1:0] w, input logic [PW-1:0] nxt, input bit nn);
    logic [2*W-1:0] r;
    int a, b;
    r = '0;
    for (int i = 0; i < PPC; i++) begin
      for (int c = 0; c < CPP; c++) begin
        a = int'(w[(i*CPP+c)*BPC +: BPC]);
        if (i < PPC-1) b = int'(w[((i+1)*CPP+c)*BPC +: BPC]);
        else           b = int'(nxt[c*BPC +: BPC]);
        r[(2*i*CPP+c)*BPC +: BPC]     = a[BPC-1:0];
        r[((2*i+1)*CPP+c)*BPC +: BPC] = nn ? a[BPC-1:0] : BPC'((a + b + 1) / 2);
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] mkword(input int p0, input int p1, input int p2, input int p3);
    logic [W-1:0] w;
    int p[4];
    p = '{p0, p1, p2, p3};
    w = '0;
    for (int i = 0; i < PPC; i++) begin
      w[(i*CPP+0)*BPC +: BPC] = BPC'(p[i]);
      w[(i*CPP+1)*BPC +: BPC] = BPC'((p[i] + 100) % 256);
      w[(i*CPP+2)*BPC +: BPC] = BPC'(255 - p[i]);
    end
    return w;
  endfunction

  function automatic logic [31:0] c0v(input logic [W-1:0] w);
    logic [31:0] r;
    for (int i = 0; i < PPC; i++) r[i*8 +: 8] = w[i*PW +: BPC];
    return r;
  endfunction

  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic lit(input string nm, input int idx, input logic [31:0] e);
    if (idx < got_q.size()) chk(nm, c0v(got_q[idx]), e);
    else chk({nm, "_missing"}, got_q.size(), idx + 1);
  endtask

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m);
    CTL_RUN_IN = 1'b0; WR_IN = 1'b0; HS_IN = 1'b0;
    step();
    exp_err = 1'b0;
    chk("err_clear", ERR_OUT, 0);
    CTL_MODE_IN = m; CTL_RUN_IN = 1'b1;
    step();
  endtask

  // Bilinear: word a at +0, word b at +2, hsync rise at +hs_off; four beats at +3..+6.
  task automatic bl_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int hs_off, input string tag);
    int t0;
    logic [2*W-1:0] ea, eb;
    ea = expand(a, b[PW-1:0], 1'b0);
    eb = expand(b, b[W-1 -: PW], 1'b0);
    got_q.delete();
    t0 = cyc;
    exp_q.push_back('{t0+3, ea[W-1:0]});
    exp_q.push_back('{t0+4, ea[2*W-1:W]});
    exp_q.push_back('{t0+5, eb[W-1:0]});
    exp_q.push_back('{t0+6, eb[2*W-1:W]});
    for (int k = 0; k < 10; k++) begin
      WR_IN  = (k == 0) || (k == 2);
      DAT_IN = (k == 2) ? b : a;
      HS_IN  = (k == hs_off);
      if (k == 3) chk({tag, "_rdy_beat1"}, RDY_OUT, 0);
      if (k == 4 && hs_off == 3) chk({tag, "_rdy_flush"}, RDY_OUT, 0);
      if (k == hs_off + 3) chk({tag, "_hs_out"}, HS_OUT, 1);
      step();
    end
    WR_IN = 1'b0; HS_IN = 1'b0;
  endtask

  // Scoreboard and per-cycle output checks.
  always @(negedge CLK_IN) begin
    if (chk_en && !RST_IN) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        chk("de_beat", DE_OUT, 1);
        chk("dat_beat", DAT_OUT, exp_q[0].dat);
        got_q.push_back(DAT_OUT);
        void'(exp_q.pop_front());
      end else begin
        chk("de_quiet", DE_OUT, 0);
      end
      chk("err_flag", ERR_OUT, exp_err);
      if (cyc >= 3) begin
        if (run_h[(cyc-1)%8] && run_h[(cyc-2)%8] && run_h[(cyc-3)%8] &&
            !rst_h[(cyc-1)%8] && !rst_h[(cyc-2)%8] && !rst_h[(cyc-3)%8])
          chk("hs_delay", HS_OUT, hs_h[(cyc-3)%8]);
        else if (!run_h[(cyc-1)%8])
          chk("hs_off", HS_OUT, 0);
      end
    end
    hs_h[cyc%8]  = HS_IN;
    run_h[cyc%8] = CTL_RUN_IN;
    rst_h[cyc%8] = RST_IN;
  end

  initial begin
    logic [W-1:0]   wa, wb;
    logic [2*W-1:0] e;
    int t0;
    for (int i = 0; i < 8; i++) begin hs_h[i] = 1'b0; run_h[i] = 1'b0; rst_h[i] = 1'b1; end
    RST_IN = 1'b1; CTL_RUN_IN = 1'b0; CTL_MODE_IN = 2'd0; HS_IN = 1'b0; WR_IN = 1'b0; DAT_IN = '0;
    step();
    CTL_RUN_IN = 1'b1; #1;
    chk("rst_rdy", RDY_OUT, 0);
    chk("rst_hs", HS_OUT, 0);
    chk("rst_dat", DAT_OUT, 0);
    chk("rst_de", DE_OUT, 0);
    chk("rst_err", ERR_OUT, 0);
    CTL_RUN_IN = 1'b0;
    step();
    RST_IN = 1'b0;
    chk_en = 1'b1;
    step();

    // Bilinear line with hsync seen in HOLD, then rounding at the top of the range.
    start_run(2'd2);
    bl_pair(mkword(10, 20, 30, 40), mkword(50, 60, 70, 80), 4, "bl");
    lit("bl_w0", 0, p4(10, 15, 20, 25));
    lit("bl_w1", 1, p4(30, 35, 40, 45));
    lit("bl_w2", 2, p4(50, 55, 60, 65));
    lit("bl_w3", 3, p4(70, 75, 80, 80));
    bl_pair(mkword(254, 255, 0, 1), mkword(1, 1, 1, 1), 4, "rnd");
    lit("rnd_w0", 0, p4(254, 255, 255, 128));
    lit("rnd_w1", 1, p4(0, 1, 1, 1));
    // Hsync arriving during BEAT1 defers the flush of the pending word.
    bl_pair(mkword(3, 7, 11, 200), mkword(100, 0, 255, 9), 3, "flush");
    lit("flush_w3", 3, p4(255, 132, 9, 9));

    // Nearest, two words at the maximum rate.
    start_run(2'd1);
    got_q.delete();
    wa = mkword(1, 2, 3, 4);
    wb = mkword(200, 201, 202, 203);
    t0 = cyc;
    e = expand(wa, '0, 1'b1);
    exp_q.push_back('{t0+1, e[W-1:0]});
    exp_q.push_back('{t0+2, e[2*W-1:W]});
    e = expand(wb, '0, 1'b1);
    exp_q.push_back('{t0+3, e[W-1:0]});
    exp_q.push_back('{t0+4, e[2*W-1:W]});
    chk("nn_rdy0", RDY_OUT, 1);
    WR_IN = 1'b1; DAT_IN = wa; step();
    WR_IN = 1'b0; chk("nn_rdy1", RDY_OUT, 0); step();
    chk("nn_rdy2", RDY_OUT, 1);
    WR_IN = 1'b1; DAT_IN = wb; step();
    WR_IN = 1'b0;
    repeat (4) step();
    lit("nn_w0", 0, p4(1, 1, 2, 2));
    lit("nn_w1", 1, p4(3, 3, 4, 4));
    lit("nn_w2", 2, p4(200, 200, 201, 201));

    // Write while not ready: dropped and flagged.
    wa = mkword(40, 41, 42, 43);
    t0 = cyc;
    e = expand(wa, '0, 1'b1);
    exp_q.push_back('{t0+1, e[W-1:0]});
    exp_q.push_back('{t0+2, e[2*W-1:W]});
    WR_IN = 1'b1; DAT_IN = wa; step();
    DAT_IN = mkword(99, 99, 99, 99); step();
    WR_IN = 1'b0; exp_err = 1'b1;
    chk("viol_err", ERR_OUT, 1);
    repeat (4) step();

    // Bypass: back-to-back words, latency 1; mode 3 behaves the same.
    for (int m = 0; m < 4; m += 3) begin
      start_run(2'(m));
      t0 = cyc;
      for (int k = 0; k < 8; k++) begin
        wa = {$urandom, $urandom, $urandom};
        exp_q.push_back('{t0+k+1, wa});
        chk("byp_rdy", RDY_OUT, 1);
        WR_IN = 1'b1; DAT_IN = wa; step();
      end
      WR_IN = 1'b0;
      repeat (3) step();
    end

    // Asynchronous reset while the second beat is due.
    start_run(2'd1);
    wa = mkword(9, 8, 7, 6);
    e = expand(wa, '0, 1'b1);
    t0 = cyc;
    exp_q.push_back('{t0+1, e[W-1:0]});
    WR_IN = 1'b1; DAT_IN = wa; step();
    WR_IN = 1'b0;
    @(negedge CLK_IN); #1;
    RST_IN = 1'b1; #1;
    chk("arst_rdy", RDY_OUT, 0);
    chk("arst_hs", HS_OUT, 0);
    chk("arst_dat", DAT_OUT, 0);
    chk("arst_de", DE_OUT, 0);
    chk("arst_err", ERR_OUT, 0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) rst_h[i] = 1'b1;
    CTL_MODE_IN = 2'd2;
    step(); step();
    RST_IN = 1'b0;
    step();
    got_q.delete();
    wa = mkword(5, 5, 5, 5);
    e = expand(wa, wa[W-1 -: PW], 1'b0);
    t0 = cyc;
    exp_q.push_back('{t0+2, e[W-1:0]});
    exp_q.push_back('{t0+3, e[2*W-1:W]});
    WR_IN = 1'b1; DAT_IN = wa; step();
    WR_IN = 1'b0; HS_IN = 1'b1; step();
    HS_IN = 1'b0;
    repeat (5) step();
    lit("post_rst_w0", 0, p4(5, 5, 5, 5));
    lit("post_rst_w1", 1, p4(5, 5, 5, 5));

    // Write coinciding with an hsync rise is dropped and flagged.
    WR_IN = 1'b1; HS_IN = 1'b1; DAT_IN = mkword(77, 77, 77, 77); step();
    WR_IN = 1'b0; HS_IN = 1'b0; exp_err = 1'b1;
    chk("hs_wr_err", ERR_OUT, 1);
    repeat (4) step();
    start_run(2'd0);
    repeat (2) step();

    chk("exp_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
